// File: rtl/expr_scheduler.sv
// Two-requester round-robin scheduler in front of a shared fixed-latency expression datapath.
// Each accepted operand vector is driven to the datapath and its result is returned tagged with the owner.
module expr_scheduler #(
  parameter int unsigned LAT = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [59:0] req0_ops,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [59:0] req1_ops,
  output logic [59:0] dp_ops,
  input  logic [89:0] dp_y,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [89:0] rsp_y,
  output logic        rsp_id,
  output logic        busy,
  output logic [15:0] issue_cnt,
  output logic [1:0]  o_dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high.
  // Producers hold valid (and payload) until ready; ready never depends on anything but
  // state, history and the valids themselves.

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam logic [3:0] LAT_W = 4'(LAT);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [3:0]  r_cnt;
  logic        r_last;
  logic        r_owner;
  logic [59:0] r_dp_ops;
  logic [89:0] r_rsp_y;
  logic        r_rsp_id;
  logic        r_rsp_valid;
  logic [15:0] r_issue_cnt;
  logic        w_grant0;
  logic        w_grant1;
  logic        w_accept;

  always_comb begin
    w_state_nxt = r_state;
    w_grant0    = 1'b0;
    w_grant1    = 1'b0;
    case (r_state)
      S_IDLE: begin
        // r_last == 1 means requester 1 won last time, so requester 0 has priority now.
        if (rst_n) begin
          w_grant1 = req1_valid && (!req0_valid || !r_last);
          w_grant0 = req0_valid && !w_grant1;
        end
        if (w_grant0 || w_grant1) w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (r_cnt == 4'd1) w_state_nxt = S_RESP;
      end
      S_RESP: begin
        if (rsp_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_accept = w_grant0 || w_grant1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= 4'd0;
      r_last      <= 1'b1;
      r_owner     <= 1'b0;
      r_dp_ops    <= 60'd0;
      r_rsp_y     <= 90'd0;
      r_rsp_id    <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_issue_cnt <= 16'd0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_dp_ops    <= w_grant1 ? req1_ops : req0_ops;
        r_cnt       <= LAT_W;
        r_owner     <= w_grant1;
        r_last      <= w_grant1;
        r_issue_cnt <= r_issue_cnt + 16'd1;
      end else if (r_state == S_WAIT) begin
        r_cnt <= r_cnt - 4'd1;
        // Counter reaching 1 marks the cycle dp_y is valid for the issued operands.
        if (r_cnt == 4'd1) begin
          r_rsp_y     <= dp_y;
          r_rsp_id    <= r_owner;
          r_rsp_valid <= 1'b1;
        end
      end else if ((r_state == S_RESP) && rsp_ready) begin
        r_rsp_valid <= 1'b0;
      end
    end
  end

  assign req0_ready  = w_grant0;
  assign req1_ready  = w_grant1;
  assign dp_ops      = r_dp_ops;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_y       = r_rsp_y;
  assign rsp_id      = r_rsp_id;
  assign busy        = (r_state != S_IDLE);
  assign issue_cnt   = r_issue_cnt;
  assign o_dbg_state = r_state;

endmodule
